// File: rtl/s27_lockstep_monitor.sv
// s27_lockstep_monitor: passive golden s27 replica run in lockstep with a DUT; flags, counts and snapshots G17 mismatches.
// MISMATCH lags its compare edge by one cycle; never drives the DUT, no backpressure; optional trigger watch via S27_LOCKSTEP_TRIGGER_EN.
module s27_lockstep_monitor #(
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             G0,
  input  logic             G1,
  input  logic             G2,
  input  logic             G3,
  input  logic             G17_DUT,
  input  logic             CLR,
  output logic             SYNCED,
  output logic             MISMATCH,
  output logic [CNT_W-1:0] MCOUNT,
  output logic             ALARM,
  output logic [2:0]       SNAP_STATE,
  output logic [3:0]       SNAP_IN,
  output logic             TRIG_SEEN
);

  typedef enum logic {ST_UNSYNC, ST_SYNC} state_t;

  localparam logic [CNT_W:0] LP_THRESH = (CNT_W+1)'(ALARM_THRESH);

  state_t r_state;
  state_t w_state_nxt;

  logic r_g5, r_g6, r_g7;
  logic w_g8, w_g9, w_g10, w_g11, w_g12, w_g13, w_g14, w_g15, w_g16, w_g17;

  logic             r_mismatch;
  logic [CNT_W-1:0] r_mcount;
  logic             r_alarm;
  logic [2:0]       r_snap_state;
  logic [3:0]       r_snap_in;

  logic             w_flush;
  logic             w_cmp_en;
  logic             w_mm;
  logic [CNT_W:0]   w_cnt_sum;
  logic             w_cnt_sat;

  // Golden s27 combinational cloud, evaluated from the replica state and live inputs.
  assign w_g14 = ~G0;
  assign w_g8  = w_g14 & r_g6;
  assign w_g12 = ~(G1 | r_g7);
  assign w_g15 = w_g12 | w_g8;
  assign w_g16 = G3 | w_g8;
  assign w_g9  = ~(w_g16 & w_g15);
  assign w_g11 = ~(r_g5 | w_g9);
  assign w_g10 = ~(w_g14 | w_g11);
  assign w_g13 = ~(G2 | w_g12);
  assign w_g17 = ~w_g11;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_g5 <= 1'b0;
      r_g6 <= 1'b0;
      r_g7 <= 1'b0;
    end else begin
      r_g5 <= w_g10;
      r_g6 <= w_g11;
      r_g7 <= w_g13;
    end
  end

  // G0&G1 forces the next s27 state to {1,0,~G2}, so after that edge the DUT state is known.
  assign w_flush = G0 & G1;

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= ST_UNSYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNSYNC: if (w_flush) w_state_nxt = ST_SYNC;
      ST_SYNC:   w_state_nxt = ST_SYNC;
      default:   w_state_nxt = ST_UNSYNC;
    endcase
  end

  assign w_cmp_en  = (r_state == ST_SYNC);
  assign w_mm      = w_cmp_en & (G17_DUT ^ w_g17);
  assign w_cnt_sum = {1'b0, r_mcount} + {{CNT_W{1'b0}}, w_mm};
  assign w_cnt_sat = &r_mcount;

  always_ff @(posedge CK) begin
    if (RST || CLR) begin
      r_mismatch   <= 1'b0;
      r_mcount     <= '0;
      r_alarm      <= 1'b0;
      r_snap_state <= 3'b000;
      r_snap_in    <= 4'b0000;
    end else begin
      r_mismatch <= w_mm;
      if (w_mm && !w_cnt_sat) begin
        r_mcount <= w_cnt_sum[CNT_W-1:0];
      end
      if (w_cnt_sum >= LP_THRESH && w_cmp_en) begin
        r_alarm <= 1'b1;
      end
      // Only the first mismatch since reset/clear is captured.
      if (w_mm && (r_mcount == '0)) begin
        r_snap_state <= {r_g5, r_g6, r_g7};
        r_snap_in    <= {G3, G2, G1, G0};
      end
    end
  end

`ifdef S27_LOCKSTEP_TRIGGER_EN
  logic r_trig_seen;
  logic w_trig;

  assign w_trig = r_g6 & w_g11 & ~w_g8 & ~w_g9 & ~w_g16;

  always_ff @(posedge CK) begin
    if (RST || CLR) begin
      r_trig_seen <= 1'b0;
    end else if (w_cmp_en && w_trig) begin
      r_trig_seen <= 1'b1;
    end
  end

  assign TRIG_SEEN = r_trig_seen;
`else
  assign TRIG_SEEN = 1'b0;
`endif

  assign SYNCED     = (r_state == ST_SYNC);
  assign MISMATCH   = r_mismatch;
  assign MCOUNT     = r_mcount;
  assign ALARM      = r_alarm;
  assign SNAP_STATE = r_snap_state;
  assign SNAP_IN    = r_snap_in;

endmodule

// File: tb/tb_s27_lockstep_monitor.sv
// Directed bench for s27_lockstep_monitor: default instance (CNT_W=8, THRESH=1) beside a narrow one (CNT_W=2, THRESH=3).
module tb_s27_lockstep_monitor;

  logic CK;
  logic RST, CLR;
  logic G0, G1, G2, G3, G17_DUT;

  logic       d1_synced, d1_mismatch, d1_alarm, d1_trig;
  logic [7:0] d1_mcount;
  logic [2:0] d1_snap_state;
  logic [3:0] d1_snap_in;

  logic       d2_synced, d2_mismatch, d2_alarm, d2_trig;
  logic [1:0] d2_mcount;
  logic [2:0] d2_snap_state;
  logic [3:0] d2_snap_in;

  int n_chk;
  int n_pass;

  s27_lockstep_monitor #(.CNT_W(8), .ALARM_THRESH(1)) u_dut1 (
    .CK(CK), .RST(RST), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .G17_DUT(G17_DUT), .CLR(CLR),
    .SYNCED(d1_synced), .MISMATCH(d1_mismatch), .MCOUNT(d1_mcount),
    .ALARM(d1_alarm), .SNAP_STATE(d1_snap_state), .SNAP_IN(d1_snap_in),
    .TRIG_SEEN(d1_trig)
  );

  s27_lockstep_monitor #(.CNT_W(2), .ALARM_THRESH(3)) u_dut2 (
    .CK(CK), .RST(RST), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .G17_DUT(G17_DUT), .CLR(CLR),
    .SYNCED(d2_synced), .MISMATCH(d2_mismatch), .MCOUNT(d2_mcount),
    .ALARM(d2_alarm), .SNAP_STATE(d2_snap_state), .SNAP_IN(d2_snap_in),
    .TRIG_SEEN(d2_trig)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, return 1 time unit after it.
  task automatic cyc(input logic [3:0] in, input logic g17);
    {G3, G2, G1, G0} = in;
    G17_DUT = g17;
    @(posedge CK);
    #1;
  endtask

  task automatic do_rst();
    RST = 1'b1;
    cyc(4'b0000, 1'b0);
    RST = 1'b0;
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_synced"},   {7'd0, d1_synced},     8'd0);
    chk({pfx, "_mismatch"}, {7'd0, d1_mismatch},   8'd0);
    chk({pfx, "_mcount"},   d1_mcount,             8'd0);
    chk({pfx, "_alarm"},    {7'd0, d1_alarm},      8'd0);
    chk({pfx, "_snap_st"},  {5'd0, d1_snap_state}, 8'd0);
    chk({pfx, "_snap_in"},  {4'd0, d1_snap_in},    8'd0);
    chk({pfx, "_trig"},     {7'd0, d1_trig},       8'd0);
    chk({pfx, "_d2_synced"}, {7'd0, d2_synced},    8'd0);
    chk({pfx, "_d2_mcount"}, {6'd0, d2_mcount},    8'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    RST = 1'b0;
    CLR = 1'b0;
    {G3, G2, G1, G0} = 4'b0000;
    G17_DUT = 1'b0;

    // Reset, then idle with toggling DUT output: no compares before a flush.
    do_rst();
    chk_idle("t1_rst");
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000, i[0]);
      chk_idle("t1_unsync");
    end

    // Flush edge (golden G17 would be 1 there, DUT shows 0: must not be compared).
    cyc(4'b0011, 1'b0);
    chk("t2_synced", {7'd0, d1_synced}, 8'd1);
    chk("t2_flush_mm", {7'd0, d1_mismatch}, 8'd0);
    // State 101, inputs 0000 -> golden G17 = 1, DUT matches.
    cyc(4'b0000, 1'b1);
    chk("t2_match_mm", {7'd0, d1_mismatch}, 8'd0);
    chk("t2_match_cnt", d1_mcount, 8'd0);

    // First compare after flush mismatches at golden state 101.
    do_rst();
    cyc(4'b0011, 1'b1);
    cyc(4'b0000, 1'b0);
    chk("t3_mm", {7'd0, d1_mismatch}, 8'd1);
    chk("t3_cnt", d1_mcount, 8'd1);
    chk("t3_alarm", {7'd0, d1_alarm}, 8'd1);
    chk("t3_snap_st", {5'd0, d1_snap_state}, 8'h05);
    chk("t3_snap_in", {4'd0, d1_snap_in}, 8'h00);
    chk("t3_d2_cnt", {6'd0, d2_mcount}, 8'd1);
    chk("t3_d2_alarm", {7'd0, d2_alarm}, 8'd0);
    cyc(4'b0000, 1'b1);
    chk("t3_mm_clear", {7'd0, d1_mismatch}, 8'd0);
    chk("t3_cnt_hold", d1_mcount, 8'd1);
    chk("t3_alarm_hold", {7'd0, d1_alarm}, 8'd1);
    chk("t3_snap_hold", {5'd0, d1_snap_state}, 8'h05);

    // Mismatch every cycle: narrow counter saturates at 3, alarm at 3.
    do_rst();
    cyc(4'b0011, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0000, 1'b0);
      chk("t4_d2_cnt", {6'd0, d2_mcount}, (i < 2) ? 8'(i + 1) : 8'd3);
      chk("t4_d2_alarm", {7'd0, d2_alarm}, (i >= 2) ? 8'd1 : 8'd0);
      chk("t4_d2_snap_st", {5'd0, d2_snap_state}, 8'h05);
      chk("t4_d2_snap_in", {4'd0, d2_snap_in}, 8'h00);
      chk("t4_d1_cnt", d1_mcount, 8'(i + 1));
      chk("t4_d2_mm", {7'd0, d2_mismatch}, 8'd1);
    end

    // CLR on a mismatching edge drops it; SYNC is kept.
    do_rst();
    cyc(4'b0011, 1'b1);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("t5_pre_cnt", d1_mcount, 8'd2);
    CLR = 1'b1;
    cyc(4'b0000, 1'b0);
    CLR = 1'b0;
    chk("t5_clr_cnt", d1_mcount, 8'd0);
    chk("t5_clr_alarm", {7'd0, d1_alarm}, 8'd0);
    chk("t5_clr_mm", {7'd0, d1_mismatch}, 8'd0);
    chk("t5_clr_synced", {7'd0, d1_synced}, 8'd1);
    chk("t5_clr_snap", {5'd0, d1_snap_state}, 8'd0);
    chk("t5_clr_d2_cnt", {6'd0, d2_mcount}, 8'd0);
    // Golden state has settled to 001; a fresh snapshot is taken there.
    cyc(4'b0000, 1'b0);
    chk("t5_post_mm", {7'd0, d1_mismatch}, 8'd1);
    chk("t5_post_cnt", d1_mcount, 8'd1);
    chk("t5_post_snap", {5'd0, d1_snap_state}, 8'h01);
    // RST together with CLR mid-run, then no compares while unsynced.
    RST = 1'b1;
    CLR = 1'b1;
    cyc(4'b0000, 1'b0);
    RST = 1'b0;
    CLR = 1'b0;
    chk_idle("t5_rst");
    cyc(4'b0000, 1'b0);
    chk_idle("t5_unsync");

    // Flush with G2=1 -> state 100; inputs 1100 walk 100 -> 000 -> 010 with golden G17 1,0,0.
    do_rst();
    cyc(4'b0111, 1'b0);
    cyc(4'b1100, 1'b1);
    chk("t7_m1", {7'd0, d1_mismatch}, 8'd0);
    cyc(4'b1100, 1'b1);
    chk("t7_mm", {7'd0, d1_mismatch}, 8'd1);
    chk("t7_snap_st", {5'd0, d1_snap_state}, 8'h00);
    chk("t7_snap_in", {4'd0, d1_snap_in}, 8'h0c);
    chk("t7_cnt", d1_mcount, 8'd1);
    cyc(4'b1100, 1'b0);
    chk("t7_m0", {7'd0, d1_mismatch}, 8'd0);
    chk("t7_cnt_hold", d1_mcount, 8'd1);
    // Flush while in SYNC (golden G17=1) keeps SYNC and compares normally.
    cyc(4'b0011, 1'b1);
    chk("t7_flush_sync", {7'd0, d1_synced}, 8'd1);
    chk("t7_flush_mm", {7'd0, d1_mismatch}, 8'd0);
    cyc(4'b0000, 1'b1);
    chk("t7_after_mm", {7'd0, d1_mismatch}, 8'd0);
    chk("t7_after_cnt", d1_mcount, 8'd1);

    // Random traffic after a flush: the trigger is unreachable on a correct s27.
    do_rst();
    cyc(4'b0011, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      cyc(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end
    chk("t6_trig", {7'd0, d1_trig}, 8'd0);
    chk("t6_d2_trig", {7'd0, d2_trig}, 8'd0);
    chk("t6_synced", {7'd0, d1_synced}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/s27_lockstep_monitor.md
Name: s27_lockstep_monitor

Overview:
Passive runtime checker that sits beside an s27 instance, including its trojan-instrumented variant. It sees the same primary inputs G0..G3 and the DUT's observed G17, and runs a resettable golden s27 replica in lockstep. It flags, counts and snapshots any cycle where the DUT output differs from the golden output. It never drives the DUT.

Parameters:
CNT_W, 8, width of saturating mismatch counter MCOUNT
ALARM_THRESH, 1, mismatch count at which ALARM asserts (1..2^CNT_W-1)

Ports:
CK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
G0  input  1  DUT primary input G0
G1  input  1  DUT primary input G1
G2  input  1  DUT primary input G2
G3  input  1  DUT primary input G3
G17_DUT  input  1  observed DUT output G17
CLR  input  1  sync clear of MISMATCH, MCOUNT, ALARM and snapshots
SYNCED  output  1  golden state known-equal to DUT state
MISMATCH  output  1  registered one-cycle flag for the compare of the previous edge
MCOUNT  output  CNT_W  saturating mismatch count
ALARM  output  1  sticky; set when MCOUNT reaches ALARM_THRESH
SNAP_STATE  output  3  golden {G5,G6,G7} at the first mismatch
SNAP_IN  output  4  {G3,G2,G1,G0} at the first mismatch
TRIG_SEEN  output  1  sticky trojan-trigger observation (optional feature)

Behaviour:
- Golden model: s27 netlist, 3 flops {G5,G6,G7} with D = {G10,G11,G13}. Combinational golden G17 = ~G11 from the current golden state and current inputs.
- Reset (RST=1 at edge): golden state 000, FSM=UNSYNC, SYNCED=0, MISMATCH=0, MCOUNT=0, ALARM=0, SNAP_STATE=0, SNAP_IN=0, TRIG_SEEN=0. RST wins over CLR and over every other event. Reset mid-operation always returns the monitor to UNSYNC.
- Flush condition: G0=1 and G1=1 sampled at an edge. This forces the next state to {G5,G6,G7} = {1,0,~G2}, independent of prior state, so the DUT state is known after that edge.
- FSM UNSYNC:
  - Golden flops update every edge; compares are suppressed.
  - On an edge sampling the flush condition: go to SYNC. SYNCED=1 from the following cycle.
- FSM SYNC:
  - At every edge, mm = G17_DUT ^ golden G17, using the values present just before the edge.
  - MISMATCH <= mm, so latency is one cycle.
  - If mm=1 and MCOUNT=0: SNAP_STATE <= golden state and SNAP_IN <= inputs.
  - MCOUNT <= MCOUNT+mm, saturating at all-ones with no wrap.
  - ALARM <= ALARM | (MCOUNT+mm >= ALARM_THRESH), using the unsaturated compare.
  - Flush condition in SYNC: stay in SYNC.
- SYNC never drops back to UNSYNC except on RST. Golden flops keep running through mismatches.
- The first compare happens at the edge after the flush edge. The flush edge itself is not compared.
- CLR=1 at edge:
  - Clears MISMATCH, MCOUNT, ALARM, SNAP_*, TRIG_SEEN.
  - A mismatch occurring on that same edge is dropped.
  - FSM, SYNCED and golden state are unaffected.

Optional Feature:
Macro S27_LOCKSTEP_TRIGGER_EN.
- Defined: golden trigger t = G6 & G11 & ~G8 & ~G9 & ~G16 is evaluated each edge while in SYNC. TRIG_SEEN <= TRIG_SEEN | t; clearable by CLR and RST.
- Undefined: TRIG_SEEN is tied 0 and no trigger logic is present.

Test Plan:
1. RST=1 one edge, then inputs 0000 and G17_DUT toggling for 5 cycles -> SYNCED=0, MISMATCH=0, MCOUNT=0, ALARM=0 throughout.
2. Flush: G0=1, G1=1, G2=0 for one edge, then G0..G3=0000 with G17_DUT=1 -> SYNCED=1; golden state 101, golden G17=1; MISMATCH=0, MCOUNT=0.
3. As 2 but G17_DUT=0 -> next cycle MISMATCH=1, MCOUNT=1, ALARM=1 (THRESH=1), SNAP_STATE=3'b101, SNAP_IN=4'b0000; MISMATCH=0 on the following cycle if the DUT then matches.
4. CNT_W=2, THRESH=3, force a mismatch every cycle for 6 cycles -> MCOUNT 1,2,3,3,3,3; ALARM rises with MCOUNT=3; snapshot unchanged after the first mismatch.
5. In SYNC with MCOUNT=2, assert CLR on a mismatching edge -> MCOUNT=0, ALARM=0, MISMATCH=0, SYNCED stays 1. RST then asserted mid-run -> UNSYNC and all outputs 0.
6. With S27_LOCKSTEP_TRIGGER_EN defined, random inputs for 10k cycles after a flush -> TRIG_SEEN remains 0, since the trigger needs G11=1 (which requires G16=1) together with G16=0. Undefined -> TRIG_SEEN is constant 0.
